dpa_frame_aligner: RTL and testbench
====================================

// Module: dpa_frame_aligner
// PURPOSE
//  Downstream of the 4-channel DPA training/monitor stage, in the clkdiv domain. Takes the 16-bit
//  deserialised word (4 ch x 4 bit) each cycle once training is done. Hunts for the periodic
//  SYNC_WORD and achieves frame lock. Streams the payload words out through a valid/ready FIFO
//  with a start-of-frame flag.
// PARAMETERS
//  NUM_CHAN    4        lanes from the DPA stage; word width W = NUM_CHAN*4
//  SYNC_WORD   16'hA5C3 frame marker; W bits
//  FRAME_LEN   4        payload words between markers, >=1
//  LOCK_CNT    2        consecutive good markers needed for lock, >=1
//  MISS_MAX    2        consecutive missed markers that drop lock, >=1
//  FIFO_DEPTH  8        payload FIFO entries, power of 2, >=2
// PORTS
//  clkdiv     in   1   divided parallel clock, sole clock
//  rst        in   1   synchronous active-high reset
//  train_done in   1   DPA training complete; low = input not trusted
//  data_in    in   W   deserialised word, ch0 in [3:0]
//  m_ready    in   1   downstream accepts m_data
//  m_valid    out  1   m_data/m_sof valid
//  m_data     out  W   payload word
//  m_sof      out  1   m_data is first payload word of a frame
//  locked     out  1   frame lock held
//  overflow   out  1   sticky: payload word dropped because FIFO was full
// BEHAVIOUR
//  - Reset: state HUNT, FIFO empty, all outputs 0, all counters 0.
//  - data_in registered once (d_r); all decisions use d_r.
//  - FSM:
//    - HUNT: d_r==SYNC_WORD -> CHECK, good=1, pos=0. Otherwise stay.
//    - CHECK: count FRAME_LEN words, then compare the marker slot.
//      - Match: good++; good==LOCK_CNT -> LOCKED.
//      - Mismatch -> HUNT. Nothing is pushed in CHECK.
//    - LOCKED: payload slots are pushed to the FIFO. At the marker slot:
//      - Match: miss=0.
//      - Mismatch: miss++; miss reaches MISS_MAX -> HUNT (locked drops on the same edge).
//      - The marker slot is never pushed, match or not.
//  - Slot position: pos counts 0..FRAME_LEN then wraps to 0; pos==FRAME_LEN is the marker slot.
//    A SYNC_WORD value in a payload slot is data.
//  - train_done low forces HUNT next edge: FIFO flushed, counters cleared; overflow is held.
//  - Push: LOCKED, payload slot, FIFO not full. The first payload after a marker carries sof=1.
//  - Latency: word on data_in at edge N -> m_valid at edge N+2 (FIFO empty, locked).
//  - Handshake: pop when m_valid&m_ready. m_data/m_sof stay stable while m_valid&!m_ready.
//    m_valid never drops without a pop, except on rst or flush.
//  - Full: a push with no simultaneous pop is dropped and sets overflow (sticky until rst).
//    Push+pop while full is accepted with no overflow.
//  - Empty: m_valid=0; push+pop while empty is impossible (no bypass path).
//  - Counter widths are $clog2 of their maximum + 1; no saturation logic is needed.
// CONFIGURATION
//  DPA_FRAME_STATS_EN defined: adds outputs frame_cnt[31:0] (good markers while LOCKED)
//  and loss_cnt[15:0] (LOCKED->HUNT transitions). Both wrap modulo 2^n, clear on rst only.
//  Undefined: these ports and their logic do not exist. All other behaviour is identical.
// STRUCTURE
//  - dpa_pkg holds:
//    - state encoding localparams: HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2
//    - default SYNC_WORD
//    - clog2 helper function
//  - Sub-module dpa_sync_fifo (width W+1, depth FIFO_DEPTH, sync flush, registered output,
//    full/empty) holds the payload FIFO. The FSM and slot counters stay in dpa_frame_aligner.
// TESTING (SYNC=16'hA5C3, FRAME_LEN=4, LOCK_CNT=2, MISS_MAX=2, FIFO_DEPTH=8)
//  - Lock: train_done=1, repeat {A5C3,0001,0002,0003,0004}, m_ready=1.
//    -> locked rises at the 2nd-marker check.
//    -> m_data sequence 0001..0004 with m_sof on 0001; markers never appear.
//  - False marker: A5C3 then 0001,A5C3,0003,0004, 1234 in the marker slot
//    -> back to HUNT, locked stays 0, nothing output.
//  - Loss: locked, then one bad marker -> stays locked. Two consecutive bad markers
//    -> locked=0 on the 2nd; loss_cnt=1 with DPA_FRAME_STATS_EN.
//  - Backpressure: locked, m_ready=0 for 12 payload words -> 8 stored, overflow=1.
//    Release m_ready -> the 8 words drain in order, then streaming resumes.
//  - Full + simultaneous pop: FIFO full, m_ready=1 with a push the same cycle
//    -> no overflow, count stays 8.
//  - Mid-run rst and train_done drop while locked with data in FIFO
//    -> next edge: m_valid=0, locked=0. overflow clears only on rst.

Source files
------------

// File: rtl/dpa_pkg.sv
// Shared definitions for the DPA frame aligner: FSM state encoding, the
// default frame marker and a constant-evaluable clog2 helper.
package dpa_pkg;

  // Frame aligner FSM state encoding
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Default frame marker for the 4-lane (16-bit) configuration
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA5C3;

  // Ceiling log2, usable in parameter/localparam expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dpa_sync_fifo.sv
// Synchronous FIFO with a registered output stage. The head entry is moved
// into the output register one cycle after it becomes available, so a word
// written into an empty FIFO is visible on rd_data two edges after it was
// presented: there is no write-to-read bypass. 'empty' reflects the output
// register, so ~empty is the downstream valid. 'full' counts every stored
// entry including the one being displayed. flush clears contents
// synchronously; rst is synchronous active-high.
module dpa_sync_fifo
  import dpa_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_left;
  logic             out_valid;
  logic             pop;
  logic             wr_accept;

  assign empty      = ~out_valid;
  assign full       = (count == CW'(DEPTH));
  assign pop        = rd_en & out_valid;
  // A full FIFO still accepts a write when the head leaves on the same edge
  assign wr_accept  = wr_en & (~full | pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  // Entries that existed before this edge and survive the pop
  assign count_left = count - CW'(pop);

  // Storage write port
  // NOTE: the storage array has no reset; only pointers, count and the output register do.
  always_ff @(posedge clk) begin
    if (wr_accept && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered output stage
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(wr_accept);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_left + CW'(wr_accept);
      out_valid <= (count_left != '0);
      if (count_left != '0) rd_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/dpa_frame_aligner.sv
// DPA frame aligner (clkdiv domain). Registers the deserialised word, hunts
// for the periodic SYNC_WORD, qualifies it LOCK_CNT times before declaring
// lock, drops lock after MISS_MAX consecutive missed markers, and streams
// payload words with a start-of-frame flag through dpa_sync_fifo.
// Optional build macro: DPA_FRAME_STATS_EN adds frame_cnt / loss_cnt outputs.
module dpa_frame_aligner
  import dpa_pkg::*;
#(
  parameter int                    NUM_CHAN   = 4,
  parameter logic [NUM_CHAN*4-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int                    FRAME_LEN  = 4,
  parameter int                    LOCK_CNT   = 2,
  parameter int                    MISS_MAX   = 2,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                    clkdiv,
  input  logic                    rst,
  input  logic                    train_done,
  input  logic [NUM_CHAN*4-1:0]   data_in,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [NUM_CHAN*4-1:0]   m_data,
  output logic                    m_sof,
  output logic                    locked,
`ifdef DPA_FRAME_STATS_EN
  output logic [31:0]             frame_cnt,
  output logic [15:0]             loss_cnt,
`endif
  output logic                    overflow
);

  localparam int W  = NUM_CHAN * 4;
  localparam int PW = clog2(FRAME_LEN) + 1;
  localparam int GW = clog2(LOCK_CNT) + 1;
  localparam int MW = clog2(MISS_MAX) + 1;

  localparam logic [PW-1:0] MARK_POS  = PW'(FRAME_LEN);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

  logic [W-1:0]  d_r;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nxt;
  logic [GW-1:0] good;
  logic [GW-1:0] good_nxt;
  logic [MW-1:0] miss;
  logic [MW-1:0] miss_nxt;

  logic          marker_slot;
  logic          marker_hit;
  logic          push_req;
  logic          push_sof;
  logic          good_marker;
  logic          lock_loss;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [W:0]    fifo_rd_data;
  logic          overflow_r;

  assign marker_slot = (pos == MARK_POS);
  assign marker_hit  = (d_r == SYNC_WORD);

  // Input capture: every decision below looks at d_r, never at data_in
  always_ff @(posedge clkdiv) begin
    if (rst) d_r <= '0;
    else     d_r <= data_in;
  end

  // FSM state and slot counters
  always_ff @(posedge clkdiv) begin
    if (rst) begin
      state <= HUNT;
      pos   <= '0;
      good  <= '0;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      good  <= good_nxt;
      miss  <= miss_nxt;
    end
  end

  // Next state: marker qualification, lock maintenance and training loss
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    good_nxt  = good;
    miss_nxt  = miss;
    if (!train_done) begin
      state_nxt = HUNT;
      pos_nxt   = '0;
      good_nxt  = '0;
      miss_nxt  = '0;
    end else begin
      case (state)
        HUNT: begin
          if (marker_hit) begin
            state_nxt = CHECK;
            good_nxt  = GW'(1);
            pos_nxt   = '0;
          end
        end
        CHECK: begin
          if (!marker_slot) begin
            pos_nxt = pos + 1'b1;
          end else if (marker_hit) begin
            pos_nxt = '0;
            if (good >= LOCK_LAST) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
              miss_nxt  = '0;
            end else begin
              good_nxt = good + 1'b1;
            end
          end else begin
            state_nxt = HUNT;
            pos_nxt   = '0;
            good_nxt  = '0;
          end
        end
        LOCKED: begin
          if (!marker_slot) begin
            pos_nxt = pos + 1'b1;
          end else begin
            pos_nxt = '0;
            if (marker_hit) begin
              miss_nxt = '0;
            end else if (miss >= MISS_LAST) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          pos_nxt   = '0;
          good_nxt  = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs of the FSM: payload push request, frame events and lock flag
  always_comb begin
    push_req    = train_done && (state == LOCKED) && !marker_slot;
    push_sof    = (pos == '0);
    good_marker = train_done && (state == LOCKED) && marker_slot && marker_hit;
    lock_loss   = (state == LOCKED) && (state_nxt == HUNT);
    locked      = (state == LOCKED);
  end

  assign pop = m_valid & m_ready;

  dpa_sync_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clkdiv),
    .rst     (rst),
    .flush   (!train_done),
    .wr_en   (push_req),
    .wr_data ({push_sof, d_r}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_sof   = fifo_rd_data[W];
  assign m_data  = fifo_rd_data[W-1:0];

  // Sticky overflow: a payload word met a full FIFO with no pop to make room
  always_ff @(posedge clkdiv) begin
    if (rst)                                  overflow_r <= 1'b0;
    else if (push_req && fifo_full && !pop)   overflow_r <= 1'b1;
  end

  assign overflow = overflow_r;

`ifdef DPA_FRAME_STATS_EN
  // Frame statistics: wrap freely, cleared only by rst
  always_ff @(posedge clkdiv) begin
    if (rst) begin
      frame_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      if (good_marker) frame_cnt <= frame_cnt + 32'd1;
      if (lock_loss)   loss_cnt  <= loss_cnt + 16'd1;
    end
  end
`else
  // Frame events only feed the statistics counters in this build
  logic unused_events;
  assign unused_events = good_marker ^ lock_loss;
`endif

endmodule

// File: tb/tb_dpa_frame_aligner.sv
// Directed self-checking bench for dpa_frame_aligner with SYNC=16'hA5C3,
// FRAME_LEN=4, LOCK_CNT=2, MISS_MAX=2, FIFO_DEPTH=8. Honours
// DPA_FRAME_STATS_EN for the optional statistics ports.
module tb_dpa_frame_aligner;

  logic        clkdiv = 1'b0;
  logic        rst;
  logic        train_done;
  logic [15:0] data_in;
  logic        m_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_sof;
  logic        locked;
  logic        overflow;
`ifdef DPA_FRAME_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] loss_cnt;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;
  int fail_cnt  = 0;

  logic [16:0] popped [$];

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam logic [15:0] BAD  = 16'h0BAD;

  always #5 clkdiv = ~clkdiv;

  dpa_frame_aligner #(
    .NUM_CHAN   (4),
    .SYNC_WORD  (16'hA5C3),
    .FRAME_LEN  (4),
    .LOCK_CNT   (2),
    .MISS_MAX   (2),
    .FIFO_DEPTH (8)
  ) dut (
    .clkdiv     (clkdiv),
    .rst        (rst),
    .train_done (train_done),
    .data_in    (data_in),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .locked     (locked),
`ifdef DPA_FRAME_STATS_EN
    .frame_cnt  (frame_cnt),
    .loss_cnt   (loss_cnt),
`endif
    .overflow   (overflow)
  );

  // Record every word the DUT hands over (values before the edge)
  always @(posedge clkdiv) begin
    if (m_valid && m_ready) popped.push_back({m_sof, m_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input int idx, input logic [16:0] exp);
    logic [16:0] obs;
    obs = (idx < popped.size()) ? popped[idx] : 17'h1FFFF;
    chk($sformatf("pop%0d", idx), 32'(obs), 32'(exp));
  endtask

  // Present one word, let one edge capture it, sample 1 time unit later
  task automatic step(input logic [15:0] d);
    data_in = d;
    @(posedge clkdiv);
    #1;
  endtask

  // Four payload words base+1..base+4 followed by the marker slot
  task automatic send_frame_m(input logic [15:0] base, input logic [15:0] marker);
    for (int i = 1; i <= 4; i++) step(16'(base + 16'(i)));
    step(marker);
  endtask

  task automatic send_frame(input logic [15:0] base);
    send_frame_m(base, SYNC);
  endtask

  initial begin
    int markers_seen;
    logic [16:0] exp_bp [10];

    rst        = 1'b1;
    train_done = 1'b0;
    m_ready    = 1'b1;
    data_in    = 16'h0000;
    step(16'h0000);
    step(16'h0000);

    // Reset state
    chk("rst_m_valid",  32'(m_valid),  32'd0);
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_m_data",   32'(m_data),   32'd0);
    chk("rst_m_sof",    32'(m_sof),    32'd0);

    // Lock acquisition: first marker + qualifying frame, payload not streamed
    rst        = 1'b0;
    train_done = 1'b1;
    step(SYNC);
    send_frame(16'h0000);
    chk("lock_pending", 32'(locked), 32'd0);
    step(16'h0011);
    chk("lock_rise",    32'(locked), 32'd1);
    chk("lat_n1_valid", 32'(m_valid), 32'd0);
    step(16'h0012);
    chk("lat_n1_still", 32'(m_valid), 32'd0);
    step(16'h0013);
    chk("lat_n2_valid", 32'(m_valid), 32'd1);
    chk("lat_n2_data",  32'(m_data),  32'h0011);
    chk("lat_n2_sof",   32'(m_sof),   32'd1);
    step(16'h0014);
    step(SYNC);
    send_frame(16'h0020);
    send_frame(16'h0030);

    chk("stream_size_ge8", 32'(popped.size() >= 8), 32'd1);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        chk_pop(f * 4 + k, {(k == 0), 16'(16'h0011 + 16'(f * 16 + k))});
      end
    end
    markers_seen = 0;
    foreach (popped[i]) if (popped[i][15:0] == SYNC) markers_seen++;
    chk("no_marker_out", 32'(markers_seen), 32'd0);

    // Loss of lock: one bad marker tolerated, two consecutive drop lock
    send_frame_m(16'h0040, BAD);
`ifdef DPA_FRAME_STATS_EN
    chk("frame_cnt_3", frame_cnt, 32'd3);
`endif
    send_frame(16'h0050);
    chk("one_miss_locked", 32'(locked), 32'd1);
    send_frame_m(16'h0060, BAD);
    send_frame_m(16'h0070, BAD);
    chk("two_miss_pre", 32'(locked), 32'd1);
    step(16'h0000);
    chk("two_miss_drop", 32'(locked), 32'd0);
`ifdef DPA_FRAME_STATS_EN
    chk("loss_cnt_1", 32'(loss_cnt), 32'd1);
`endif
    for (int i = 0; i < 10; i++) step(16'h0000);
    popped.delete();

    // False marker: SYNC value in a payload slot, wrong word in marker slot
    step(SYNC);
    step(16'h0001);
    step(SYNC);
    step(16'h0003);
    step(16'h0004);
    step(16'h1234);
    send_frame(16'h0080);
    chk("false_no_lock", 32'(locked), 32'd0);
    send_frame(16'h0090);
    chk("false_no_out",   32'(popped.size()), 32'd0);
    chk("false_no_valid", 32'(m_valid), 32'd0);

    // Backpressure: exactly 8 payload words fill the FIFO without overflow
    m_ready = 1'b0;
    send_frame(16'h00A0);
    chk("bp_locked", 32'(locked), 32'd1);
    send_frame(16'h00B0);
    chk("bp_full_no_ovf", 32'(overflow), 32'd0);
    chk("bp_head_valid",  32'(m_valid),  32'd1);
    chk("bp_head_data",   32'(m_data),   32'h00A1);
    step(16'h00C1);
    // Push into a full FIFO while the head is popped: accepted, no overflow
    m_ready = 1'b1;
    step(16'h00C2);
    m_ready = 1'b0;
    chk("full_pop_no_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head",   32'(m_data),   32'h00A2);
    chk("full_pop_sof",    32'(m_sof),    32'd0);
    step(16'h00C3);
    chk("full_drop_ovf", 32'(overflow), 32'd1);
    step(16'h00C4);
    step(SYNC);
    m_ready = 1'b1;
    send_frame(16'h00D0);
    send_frame(16'h00E0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    exp_bp[0] = {1'b1, 16'h00A1};
    exp_bp[1] = {1'b0, 16'h00A2};
    exp_bp[2] = {1'b0, 16'h00A3};
    exp_bp[3] = {1'b0, 16'h00A4};
    exp_bp[4] = {1'b1, 16'h00B1};
    exp_bp[5] = {1'b0, 16'h00B2};
    exp_bp[6] = {1'b0, 16'h00B3};
    exp_bp[7] = {1'b0, 16'h00B4};
    exp_bp[8] = {1'b1, 16'h00C1};
    exp_bp[9] = {1'b1, 16'h00D1};
    chk("drain_size_ge10", 32'(popped.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) chk_pop(i, exp_bp[i]);

    // train_done drop while locked with data queued
    m_ready = 1'b0;
    send_frame(16'h00F0);
    chk("td_pre_valid", 32'(m_valid), 32'd1);
    train_done = 1'b0;
    step(16'h0000);
    chk("td_valid",    32'(m_valid),  32'd0);
    chk("td_locked",   32'(locked),   32'd0);
    chk("td_overflow", 32'(overflow), 32'd1);
`ifdef DPA_FRAME_STATS_EN
    chk("loss_cnt_2", 32'(loss_cnt), 32'd2);
`endif

    // Re-lock, queue data, then synchronous reset
    train_done = 1'b1;
    step(SYNC);
    send_frame(16'h0010);
    send_frame(16'h0020);
    chk("relock_locked", 32'(locked),  32'd1);
    chk("relock_valid",  32'(m_valid), 32'd1);
    rst = 1'b1;
    step(16'h0000);
    chk("mid_rst_valid",    32'(m_valid),  32'd0);
    chk("mid_rst_locked",   32'(locked),   32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
`ifdef DPA_FRAME_STATS_EN
    chk("mid_rst_frames", frame_cnt,       32'd0);
    chk("mid_rst_losses", 32'(loss_cnt),   32'd0);
`endif
    rst = 1'b0;
    step(16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
